// File: rtl/eval_sched_pkg.sv
// Shared record type and default widths for the RTLola evaluation scheduler.
package eval_sched_pkg;

  localparam int DATA_W     = 64;
  localparam int TS_W       = 32;
  localparam int NUM_LAYERS = 4;

  // One timestamped event; data carries the signed input value as raw bits.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              has_input;
    logic              has_periodic;
    logic [TS_W-1:0]   ts;
  } event_rec_t;

endpackage

// File: rtl/event_queue.sv
// Bounded synchronous FIFO of event records with occupancy level.
module event_queue
  import eval_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  event_rec_t       din,
  output event_rec_t       dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  event_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage is left out of reset; clearing the pointers and count
  // empties the queue, and stale entries are never read before rewrite.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/eval_scheduler.sv
// Event scheduler feeding the RTLola evaluation pipeline.
// Define PIPELINED_EVAL_EN to let records overlap in the layer pipeline.
module eval_scheduler
  import eval_sched_pkg::event_rec_t;
#(
  parameter int DATA_W      = eval_sched_pkg::DATA_W,
  parameter int TS_W        = eval_sched_pkg::TS_W,
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_LAYERS  = eval_sched_pkg::NUM_LAYERS,
  parameter int PERIOD      = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic signed [DATA_W-1:0]         input_0,
  input  logic                             new_input_0,
  output logic                             q_push,
  output logic                             q_push_valid,
  output logic                             q_pop,
  output logic                             q_pop_valid,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] q_level,
  output logic                             overflow,
  output logic signed [DATA_W-1:0]         ev_data,
  output logic [TS_W-1:0]                  ev_ts,
  output logic [NUM_LAYERS-1:0]            layer_en,
  output logic [NUM_LAYERS-1:0]            pacing_in,
  output logic [NUM_LAYERS-1:0]            pacing_per
);

  localparam int PCNT_W = $clog2(PERIOD);
  localparam int LVL_W  = $clog2(QUEUE_DEPTH + 1);

  logic [TS_W-1:0]       ts;
  logic [PCNT_W-1:0]     pcnt;
  logic                  tick;
  logic                  trig;
  event_rec_t            rec_d;
  event_rec_t            rec_q;
  logic                  rec_vld;
  event_rec_t            head;
  logic                  q_full;
  logic                  q_empty;
  logic                  slot_free;
  event_rec_t            stage [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] stage_vld;

  assign tick = (pcnt == PCNT_W'(PERIOD - 1));
  assign trig = new_input_0 | tick;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts   <= '0;
      pcnt <= '0;
    end else if (en) begin
      ts   <= ts + TS_W'(1);
      pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
    end
  end

  // NOTE: the struct gets a full default first so no field can infer a latch.
  always_comb begin
    rec_d              = '0;
    rec_d.data         = new_input_0 ? input_0 : '0;
    rec_d.has_input    = new_input_0;
    rec_d.has_periodic = tick;
    rec_d.ts           = ts;
  end

  // A coinciding input and tick collapse into this single formation register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_vld <= 1'b0;
      rec_q   <= '0;
    end else if (en) begin
      rec_vld <= trig;
      rec_q   <= rec_d;
    end
  end

`ifdef PIPELINED_EVAL_EN
  assign slot_free = 1'b1;
`else
  // One record in flight: wait until it reaches the last layer.
  always_comb begin
    slot_free = 1'b1;
    for (int k = 0; k < NUM_LAYERS - 1; k++) begin
      if (stage_vld[k]) slot_free = 1'b0;
    end
  end
`endif

  assign q_push       = en & rec_vld;
  assign q_pop        = en & ~q_empty & slot_free;
  assign q_push_valid = q_push & (~q_full | q_pop);
  assign q_pop_valid  = q_pop;

  event_queue #(
    .DEPTH (QUEUE_DEPTH),
    .LVL_W (LVL_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push_valid),
    .pop   (q_pop),
    .din   (rec_q),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .level (q_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (q_push && !q_push_valid) begin
      overflow <= 1'b1;
    end
  end

  // Empty stages hold an all-zero record so idle outputs read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld <= '0;
      for (int k = 0; k < NUM_LAYERS; k++) stage[k] <= '0;
    end else if (en) begin
      stage_vld[0] <= q_pop;
      stage[0]     <= q_pop ? head : '0;
      for (int k = 1; k < NUM_LAYERS; k++) begin
        stage_vld[k] <= stage_vld[k-1];
        stage[k]     <= stage[k-1];
      end
    end
  end

  assign layer_en = stage_vld;
  assign ev_data  = $signed(stage[0].data);
  assign ev_ts    = stage[0].ts;

  always_comb begin
    pacing_in  = '0;
    pacing_per = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      pacing_in[k]  = stage_vld[k] & stage[k].has_input;
      pacing_per[k] = stage_vld[k] & stage[k].has_periodic;
    end
  end

endmodule
